psram_qspi_engine: RTL and testbench

Quad-SPI transaction engine that drives an external PSRAM (EBh quad read, 38h quad write) from a simple single-shot request port. It sits between the bus-side PSRAM controller logic and the pads: it generates `sck`, `ce_n` and the 4-bit `dio` bundle, serialises command, address and write data, and deserialises read data. One request moves 1–4 bytes, little-endian.

---
 rtl/psram_pkg.sv | 25 ++
 rtl/psram_qspi_engine.sv | 189 ++++++++++++++++++
 tb/tb_psram_qspi_engine.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// Shared constants and types for the PSRAM quad-SPI transaction engine.
package psram_pkg;

    localparam logic [7:0]  CMD_QREAD    = 8'hEB;
    localparam logic [7:0]  CMD_QWRITE   = 8'h38;
    localparam int unsigned CMD_BITS     = 8;
    localparam int unsigned ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StRd,
        StWr,
        StDone
    } state_e;

    // Reorder write data so that shifting out the top nibble first yields
    // byte 0 high, byte 0 low, byte 1 high, ...
    function automatic logic [31:0] wr_nibble_order(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/psram_qspi_engine.sv
// Quad-SPI engine for PSRAM: EBh quad read / 38h quad write of 1-4 bytes.
// sck runs at clk/2; outputs to the pads change only on edges that leave sck low.
module psram_qspi_engine
    import psram_pkg::*;
#(
    parameter int unsigned DUMMY = 6
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        wr_i,
    input  logic [23:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        sck_o,
    output logic        ce_n_o,
    output logic [3:0]  dout_o,
    output logic [3:0]  douten_o,
    input  logic [3:0]  din_i
);

    localparam int unsigned CntW = 8;

    state_e          state_q, state_d;
    logic            lead_q, lead_d;   // one clk of setup before ce_n drops
    logic            sck_q, sck_d;
    logic [CntW-1:0] cnt_q, cnt_d;     // sck cycles left in phase, minus one
    logic [31:0]     sh_q, sh_d;       // outgoing cmd/addr/data, MSB first
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;

    logic [CntW-1:0] data_cnt;         // 2*(size+1)-1 nibbles
    logic [2:0]      nib_idx;
    logic [4:0]      nib_pos;
    logic            last;

    assign data_cnt = CntW'({size_q, 1'b1});
    assign nib_idx  = {size_q, 1'b1} - cnt_q[2:0];
    // Byte k lands at bit 8k; its first (high) nibble at 8k+4.
    assign nib_pos  = {nib_idx[2:1], ~nib_idx[0], 2'b00};
    assign last     = (cnt_q == '0);

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            lead_q  <= 1'b0;
            sck_q   <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            lead_q  <= lead_d;
            sck_q   <= sck_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
        end
    end

    // Next-state: accept, sck toggling, and phase advance on sck falling.
    always_comb begin
        state_d = state_q;
        lead_d  = lead_q;
        sck_d   = sck_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        size_d  = size_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StCmd;
                    lead_d  = 1'b1;
                    sck_d   = 1'b0;
                    wr_d    = wr_i;
                    size_d  = size_i;
                    wdata_d = wdata_i;
                    rdata_d = '0;
                    sh_d    = {(wr_i ? CMD_QWRITE : CMD_QREAD), addr_i};
                    cnt_d   = CntW'(CMD_BITS - 1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                if (lead_q) begin
                    lead_d = 1'b0;
                end else if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    sck_d = 1'b0;
                    cnt_d = cnt_q - CntW'(1);
                    case (state_q)
                        StCmd: begin
                            sh_d = {sh_q[30:0], 1'b0};
                            if (last) begin
                                state_d = StAddr;
                                cnt_d   = CntW'(ADDR_NIBBLES - 1);
                            end
                        end
                        StAddr: begin
                            sh_d = {sh_q[27:0], 4'b0000};
                            if (last) begin
                                if (wr_q) begin
                                    state_d = StWr;
                                    cnt_d   = data_cnt;
                                    sh_d    = wr_nibble_order(wdata_q);
                                end else if (DUMMY == 0) begin
                                    state_d = StRd;
                                    cnt_d   = data_cnt;
                                end else begin
                                    state_d = StDummy;
                                    cnt_d   = CntW'(DUMMY - 1);
                                end
                            end
                        end
                        StDummy: begin
                            if (last) begin
                                state_d = StRd;
                                cnt_d   = data_cnt;
                            end
                        end
                        StRd: begin
                            rdata_d[nib_pos +: 4] = din_i;
                            if (last) begin
                                state_d = StDone;
                            end
                        end
                        StWr: begin
                            sh_d = {sh_q[27:0], 4'b0000};
                            if (last) begin
                                state_d = StDone;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Pad outputs decoded from the registered state.
    always_comb begin
        ce_n_o   = 1'b1;
        dout_o   = 4'b0000;
        douten_o = 4'b0000;
        if (!lead_q) begin
            case (state_q)
                StCmd: begin
                    ce_n_o   = 1'b0;
                    dout_o   = {3'b000, sh_q[31]};
                    douten_o = 4'b0001;
                end
                StAddr, StWr: begin
                    ce_n_o   = 1'b0;
                    dout_o   = sh_q[31:28];
                    douten_o = 4'b1111;
                end
                StDummy, StRd: begin
                    ce_n_o = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign sck_o   = sck_q;
    assign busy_o  = (state_q != StIdle);
    assign done_o  = (state_q == StDone);
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_psram_qspi_engine.sv
// Directed bench for psram_qspi_engine with a behavioural quad-SPI PSRAM model.
module tb_psram_qspi_engine;

    localparam int Dummy = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        wr = 1'b0;
    logic [23:0] addr = '0;
    logic [1:0]  size = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  din = '0;
    logic [31:0] rdata;
    logic        busy, done, sck, ce_n;
    logic [3:0]  dout, douten;

    int n_cmp = 0;
    int n_err = 0;

    psram_qspi_engine #(.DUMMY(Dummy)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .wr_i     (wr),
        .addr_i   (addr),
        .size_i   (size),
        .wdata_i  (wdata),
        .rdata_o  (rdata),
        .busy_o   (busy),
        .done_o   (done),
        .sck_o    (sck),
        .ce_n_o   (ce_n),
        .dout_o   (dout),
        .douten_o (douten),
        .din_i    (din)
    );

    always #5 clk = ~clk;

    // PSRAM model: samples on sck rising, drives read nibbles after sck falling.
    bit   [7:0]  mem [0:4095];
    int          m_cnt = 0;
    logic [7:0]  m_cmd = '0;
    logic [23:0] m_addr = '0;
    logic [3:0]  m_hi = '0;
    int          wn, rn;
    logic [23:0] wa, ra;
    logic [7:0]  rb;

    always @(posedge sck or posedge ce_n) begin
        if (ce_n) begin
            m_cnt = 0;
        end else begin
            if (m_cnt < 8) begin
                m_cmd = {m_cmd[6:0], dout[0]};
            end else if (m_cnt < 14) begin
                m_addr = {m_addr[19:0], dout};
            end else if (m_cmd == 8'h38) begin
                wn = m_cnt - 14;
                if (wn % 2 == 0) begin
                    m_hi = dout;
                end else begin
                    wa = m_addr + 24'(wn / 2);
                    mem[wa[11:0]] = {m_hi, dout};
                end
            end
            m_cnt++;
        end
    end

    always @(negedge sck) begin
        if (!ce_n && m_cmd == 8'hEB && m_cnt >= 14 + Dummy) begin
            rn  = m_cnt - 14 - Dummy;
            ra  = m_addr + 24'(rn / 2);
            rb  = mem[ra[11:0]];
            din = (rn % 2 == 0) ? rb[7:4] : rb[3:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns on the first negedge after accept.
    task automatic launch(input logic w, input logic [23:0] a, input logic [1:0] s,
                          input logic [31:0] d);
        @(negedge clk);
        wr = w; addr = a; size = s; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sample m-th negedge after accept until done; m_done = -1 on timeout.
    task automatic wait_done(input bit pulse, input int c, input bit is_rd,
                             output int m_done, output int ce_low,
                             output int bad_cmd, output int bad_rd);
        m_done = -1; ce_low = 0; bad_cmd = 0; bad_rd = 0;
        for (int m = 1; m <= 400; m++) begin
            if (ce_n === 1'b0) ce_low++;
            if (m >= 2 && m <= 17 && (douten !== 4'b0001 || dout[3:1] !== 3'b000)) bad_cmd++;
            if (is_rd && m >= 30 && m <= 2 * c + 1 && douten !== 4'b0000) bad_rd++;
            if (pulse && m == 20) begin start = 1'b1; addr = 24'hFFFFFF; wr = ~wr; end
            if (pulse && m == 21) start = 1'b0;
            if (done === 1'b1) begin
                m_done = m;
                break;
            end
            @(negedge clk);
        end
    endtask

    int md, cl, bc, br, ndone;

    initial begin
        // Reset values
        #12;
        chk("rst_ce_n", 32'(ce_n), 32'h1);
        chk("rst_sck", 32'(sck), 32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_douten", 32'(douten), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 1 byte 0xA5 to 0x10: C = 16
        launch(1'b1, 24'h000010, 2'd0, 32'h000000A5);
        chk("w1_busy", 32'(busy), 32'h1);
        wait_done(1'b0, 16, 1'b0, md, cl, bc, br);
        chk("w1_done_at", 32'(md), 32'd34);
        chk("w1_ce_low", 32'(cl), 32'd32);
        chk("w1_cmd_oe", 32'(bc), 32'd0);
        chk("w1_model_cmd", 32'(m_cmd), 32'h38);
        chk("w1_model_addr", 32'(m_addr), 32'h10);
        chk("w1_mem10", 32'(mem[12'h010]), 32'hA5);
        chk("w1_mem11", 32'(mem[12'h011]), 32'h00);
        repeat (2) @(negedge clk);

        // Write 4 bytes DEADBEEF to 0x100: C = 22
        launch(1'b1, 24'h000100, 2'd3, 32'hDEADBEEF);
        wait_done(1'b0, 22, 1'b0, md, cl, bc, br);
        chk("w4_done_at", 32'(md), 32'd46);
        chk("w4_mem100", 32'(mem[12'h100]), 32'hEF);
        chk("w4_mem101", 32'(mem[12'h101]), 32'hBE);
        chk("w4_mem102", 32'(mem[12'h102]), 32'hAD);
        chk("w4_mem103", 32'(mem[12'h103]), 32'hDE);
        repeat (2) @(negedge clk);

        // Read 4 bytes from 0x100: C = 28
        launch(1'b0, 24'h000100, 2'd3, 32'h0);
        wait_done(1'b0, 28, 1'b1, md, cl, bc, br);
        chk("r4_done_at", 32'(md), 32'd58);
        chk("r4_ce_low", 32'(cl), 32'd56);
        chk("r4_rdata", rdata, 32'hDEADBEEF);
        chk("r4_cmd_oe", 32'(bc), 32'd0);
        chk("r4_rd_oe", 32'(br), 32'd0);
        @(negedge clk);
        chk("r4_done_pulse", 32'(done), 32'h0);
        chk("r4_rdata_hold", rdata, 32'hDEADBEEF);
        repeat (2) @(negedge clk);

        // Read 3 bytes from 0x101 with a stray start mid-transaction: C = 26
        launch(1'b0, 24'h000101, 2'd2, 32'h0);
        wait_done(1'b1, 26, 1'b1, md, cl, bc, br);
        chk("r3_done_at", 32'(md), 32'd54);
        chk("r3_rdata", rdata, 32'h00DEADBE);
        chk("r3_cmd_oe", 32'(bc), 32'd0);
        chk("r3_rd_oe", 32'(br), 32'd0);
        // start held from the done cycle: ignored there, accepted one cycle later
        wr = 1'b0; addr = 24'h000010; size = 2'd0; start = 1'b1;
        @(negedge clk);
        chk("b2b_ignored", 32'(busy), 32'h0);
        chk("b2b_single_done", 32'(done), 32'h0);
        chk("b2b_rdata_hold", rdata, 32'h00DEADBE);
        @(negedge clk);
        chk("b2b_accept", 32'(busy), 32'h1);
        start = 1'b0;
        wait_done(1'b0, 22, 1'b1, md, cl, bc, br);
        chk("b2b_done_at", 32'(md), 32'd46);
        chk("b2b_rdata", rdata, 32'h000000A5);
        repeat (2) @(negedge clk);

        // Reset during ADDR of a write: outputs idle at once, no done
        launch(1'b1, 24'h000200, 2'd3, 32'h11223344);
        repeat (19) @(negedge clk);
        chk("rstm_ce_before", 32'(ce_n), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rstm_ce_n", 32'(ce_n), 32'h1);
        chk("rstm_sck", 32'(sck), 32'h0);
        chk("rstm_douten", 32'(douten), 32'h0);
        chk("rstm_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (80) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("rstm_no_done", 32'(ndone), 32'd0);
        chk("rstm_mem200", 32'(mem[12'h200]), 32'h00);

        // Read 1 byte from 0x10 after the aborted write: C = 22
        launch(1'b0, 24'h000010, 2'd0, 32'h0);
        wait_done(1'b0, 22, 1'b1, md, cl, bc, br);
        chk("r1_done_at", 32'(md), 32'd46);
        chk("r1_rdata", rdata, 32'h000000A5);
        chk("r1_rd_oe", 32'(br), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
